axi4_mem_slave: RTL and testbench
=================================

// Module: axi4_mem_slave
// PURPOSE
//  AXI4 responder (slave) backing a byte-writable 64-bit memory; the target end of the LSU/IFU AXI4 master channels (AW/W/B, AR/R).
//  Serves single-beat and INCR bursts, merges write strobes into memory, returns OKAY/SLVERR, echoes IDs.
// PARAMETERS
//  DEPTH_WORDS  4096           number of 64-bit words in the array (power of two)
//  BASE_ADDR    32'h8000_0000  byte address of word 0; decoded range is BASE_ADDR .. BASE_ADDR+DEPTH_WORDS*8-1
//  RD_LATENCY   1              cycles from AR handshake to first rvalid (>=1)
// PORTS
//  clock    in   1   system clock
//  reset    in   1   synchronous, active-high reset
//  awvalid  in   1   write address valid
//  awready  out  1   write address ready
//  awaddr   in   32  write byte address (`AXI4_AWADDR_BUS)
//  awid     in   4   write ID (`AXI4_AWID_BUS)
//  awlen    in   8   beats-1 (`AXI4_AWLEN_BUS)
//  wvalid   in   1   write data valid
//  wready   out  1   write data ready
//  wdata    in   64  write data, byte lanes already positioned by the master
//  wstrb    in   8   byte enables, bit i -> wdata[8i+7:8i]
//  wlast    in   1   last write beat
//  bvalid   out  1   write response valid
//  bready   in   1   write response ready
//  bid      out  4   echo of captured awid
//  bresp    out  2   2'b00 OKAY / 2'b10 SLVERR
//  arvalid  in   1   read address valid
//  arready  out  1   read address ready
//  araddr   in   32  read byte address (`AXI4_ARADDR_BUS)
//  arid     in   4   read ID
//  arlen    in   8   beats-1
//  rvalid   out  1   read data valid
//  rready   in   1   read data ready
//  rdata    out  64  full 64-bit word; master selects lanes
//  rresp    out  2   2'b00 OKAY / 2'b10 SLVERR
//  rid      out  4   echo of captured arid
//  rlast    out  1   last read beat
// BEHAVIOUR
//  Reset (sync): both FSMs -> IDLE; awready=arready=1, wready=bvalid=rvalid=rlast=0, bid=rid=bresp=rresp=0, rdata=0. Memory not cleared; in-flight bursts dropped without response.
//  Write FSM W_IDLE->W_DATA->W_RESP: awready=1 only in W_IDLE; AW handshake captures addr/id/len, beat count=0. In W_DATA wready=1; each W handshake writes bytes where wstrb=1 into word idx, idx+=1, count+=1.
//  Write cont.: beat with count==len -> W_RESP next cycle, bvalid=1 held until bready, then W_IDLE. Out-of-range beat: no write, sticky err. wlast!=(count==len) on any beat: sticky err. bresp=err?SLVERR:OKAY.
//  Read FSM R_IDLE->R_WAIT->R_DATA: arready=1 only in R_IDLE; AR accepted at cycle T -> rvalid=1 at T+RD_LATENCY (R_WAIT counts RD_LATENCY-1 cycles, skipped when 1).
//  Read cont.: rdata/rresp/rlast stable while rvalid&&!rready; each R handshake advances one beat, next beat valid next cycle (1 beat/cycle with rready high). rlast=1 on beat len only; after its handshake -> R_IDLE.
//  Address: idx=(addr-BASE_ADDR)>>3, burst incr 8 bytes/beat, INCR only; awsize/arsize/awburst/arburst not consumed. In range iff BASE_ADDR<=addr<BASE_ADDR+DEPTH_WORDS*8 per beat; out-of-range read beat: rdata=0, rresp=SLVERR.
//  Channels independent: AW and AR accepted same cycle; write+read on same word same cycle -> read returns pre-write data; write visible to any read data sampled on a later edge. awlen=255 -> 256 beats, no wrap of idx inside range check.
// STRUCTURE
//  AXI4 bus-width macros and AXI4_RESP_OKAY/AXI4_RESP_SLVERR constants go in defines.v; FSM state encodings local.
//  One sub-module: axi4_mem_array (DEPTH_WORDS x 64, one strobed write port, one synchronous read port).
// TESTING
//  AW 0x8000_0004 len0, W 0x1234_5678_0000_0000 strb 0xF0 -> bresp 00 bid=awid; AR same -> rdata[63:32]=0x12345678, [31:0] unchanged, rlast=1.
//  AR 0x8000_0000 arlen=3, rready toggled 1,0,1,0.. -> 4 beats in order, rlast only on 4th, rdata stable during stalls.
//  AR 0x7FFF_FFF8 -> rresp 10, rdata 0; AW 0x8000_8000 (DEPTH 4096) write -> bresp 10, memory unchanged.
//  AW and AR same cycle, bready held 0 for 5 cycles -> read completes, bvalid stays 1 until bready, no lost response.
//  reset asserted on W beat 2 of 4 -> next cycle awready=1, wready=0, bvalid=0; beats 3-4 not written.

Source files
------------

// File: rtl/axi4_mem_slave_pkg.sv
// axi4_mem_slave_pkg
//   Shared AXI4 bus widths, response codes and the burst-context struct used
//   by the memory responder. No ports; imported by axi4_mem_slave and
//   axi4_mem_array.
package axi4_mem_slave_pkg;

  localparam int AXI4_ADDR_W = 32;
  localparam int AXI4_ID_W   = 4;
  localparam int AXI4_LEN_W  = 8;
  localparam int AXI4_DATA_W = 64;
  localparam int AXI4_STRB_W = AXI4_DATA_W / 8;

  localparam logic [1:0] AXI4_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI4_RESP_SLVERR = 2'b10;

  // Captured burst context. The byte address carries one extra bit so a
  // long burst near the top of the 32-bit space never wraps back into range.
  typedef struct packed {
    logic [AXI4_ADDR_W:0]   addr;
    logic [AXI4_ID_W-1:0]   id;
    logic [AXI4_LEN_W-1:0]  len;
    logic [AXI4_LEN_W-1:0]  cnt;
  } burst_t;

endpackage

// File: rtl/axi4_mem_array.sv
// axi4_mem_array
//   DEPTH_WORDS x 64-bit storage with one byte-strobed write port and one
//   synchronous read port. A read and write of the same word on the same
//   edge returns the old contents.
// Ports
//   clock          system clock
//   we/w_idx       write enable / word index
//   wdata/wstrb    write data / byte enables (bit i -> wdata[8i+7:8i])
//   re/r_idx       read enable / word index
//   rdata          registered read data, holds while re is low
module axi4_mem_array
  import axi4_mem_slave_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                   clock,
  input  logic                   we,
  input  logic [IDX_W-1:0]       w_idx,
  input  logic [AXI4_DATA_W-1:0] wdata,
  input  logic [AXI4_STRB_W-1:0] wstrb,
  input  logic                   re,
  input  logic [IDX_W-1:0]       r_idx,
  output logic [AXI4_DATA_W-1:0] rdata
);

  logic [AXI4_DATA_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (we) begin
      for (int b = 0; b < AXI4_STRB_W; b++) begin
        if (wstrb[b]) mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata <= mem[r_idx];
  end

endmodule

// File: rtl/axi4_mem_slave.sv
// axi4_mem_slave
//   AXI4 responder backed by a byte-writable 64-bit memory. INCR bursts only
//   (8 bytes per beat), IDs echoed, OKAY/SLVERR responses. Write and read
//   channels run independent FSMs.
// Ports
//   clock, reset                  clock, synchronous active-high reset
//   aw*  (valid/ready/addr/id/len) write address channel
//   w*   (valid/ready/data/strb/last) write data channel
//   b*   (valid/ready/id/resp)     write response channel
//   ar*  (valid/ready/addr/id/len) read address channel
//   r*   (valid/ready/data/resp/id/last) read data channel
module axi4_mem_slave
  import axi4_mem_slave_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          RD_LATENCY  = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [AXI4_ADDR_W-1:0] awaddr,
  input  logic [AXI4_ID_W-1:0]   awid,
  input  logic [AXI4_LEN_W-1:0]  awlen,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [AXI4_DATA_W-1:0] wdata,
  input  logic [AXI4_STRB_W-1:0] wstrb,
  input  logic                   wlast,
  output logic                   bvalid,
  input  logic                   bready,
  output logic [AXI4_ID_W-1:0]   bid,
  output logic [1:0]             bresp,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [AXI4_ADDR_W-1:0] araddr,
  input  logic [AXI4_ID_W-1:0]   arid,
  input  logic [AXI4_LEN_W-1:0]  arlen,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [AXI4_DATA_W-1:0] rdata,
  output logic [1:0]             rresp,
  output logic [AXI4_ID_W-1:0]   rid,
  output logic                   rlast
);

  localparam int IDX_W     = $clog2(DEPTH_WORDS);
  localparam int WAIT_LAST = (RD_LATENCY > 1) ? RD_LATENCY - 2 : 0;
  localparam logic [AXI4_ADDR_W:0] LO_ADDR = {1'b0, BASE_ADDR};
  localparam logic [AXI4_ADDR_W:0] HI_ADDR = LO_ADDR + (33'(DEPTH_WORDS) << 3);
  localparam logic [AXI4_ADDR_W:0] BEAT    = 33'd8;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

  function automatic logic in_range(input logic [AXI4_ADDR_W:0] a);
    return (a >= LO_ADDR) && (a < HI_ADDR);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [AXI4_ADDR_W:0] a);
    logic [AXI4_ADDR_W:0] off;
    off = a - LO_ADDR;
    return off[IDX_W+2:3];
  endfunction

  // ---------------- write channel ----------------
  w_state_e w_state, w_state_nx;
  burst_t   wb;
  logic     w_err;
  logic     w_beat, w_last_beat, mem_we;

  always_comb begin
    w_state_nx  = w_state;
    awready     = (w_state == W_IDLE);
    wready      = (w_state == W_DATA);
    bvalid      = (w_state == W_RESP);
    bresp       = (bvalid && w_err) ? AXI4_RESP_SLVERR : AXI4_RESP_OKAY;
    w_beat      = wready && wvalid;
    w_last_beat = (wb.cnt == wb.len);
    // reset can coincide with a beat; that beat is part of the dropped burst
    mem_we      = w_beat && in_range(wb.addr) && !reset;
    case (w_state)
      W_IDLE:  if (awvalid) w_state_nx = W_DATA;
      W_DATA:  if (wvalid && w_last_beat) w_state_nx = W_RESP;
      W_RESP:  if (bready) w_state_nx = W_IDLE;
      default: w_state_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_state <= W_IDLE;
      wb      <= '0;
      w_err   <= 1'b0;
    end else begin
      w_state <= w_state_nx;
      if (awready && awvalid) begin
        wb.addr <= {1'b0, awaddr};
        wb.id   <= awid;
        wb.len  <= awlen;
        wb.cnt  <= '0;
        w_err   <= 1'b0;
      end
      if (w_beat) begin
        wb.addr <= wb.addr + BEAT;
        wb.cnt  <= wb.cnt + 8'd1;
        w_err   <= w_err | !in_range(wb.addr) | (wlast != w_last_beat);
      end
    end
  end

  assign bid = wb.id;

  // ---------------- read channel ----------------
  r_state_e               r_state, r_state_nx;
  burst_t                 rb;
  logic                   r_err;
  logic [15:0]            r_wait;
  logic                   rd_en;
  logic [AXI4_ADDR_W:0]   rd_addr;
  logic [AXI4_DATA_W-1:0] mem_q;

  // The array read is issued on the edge that precedes each rvalid beat, so
  // mem_q (and r_err) hold the current beat for as long as the master stalls.
  always_comb begin
    r_state_nx = r_state;
    rd_en      = 1'b0;
    rd_addr    = rb.addr;
    arready    = (r_state == R_IDLE);
    rvalid     = (r_state == R_DATA);
    rlast      = rvalid && (rb.cnt == rb.len);
    case (r_state)
      R_IDLE: begin
        if (arvalid) begin
          if (RD_LATENCY == 1) begin
            r_state_nx = R_DATA;
            rd_en      = 1'b1;
            rd_addr    = {1'b0, araddr};
          end else begin
            r_state_nx = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (r_wait == 16'(WAIT_LAST)) begin
          rd_en      = 1'b1;
          r_state_nx = R_DATA;
        end
      end
      R_DATA: begin
        if (rready) begin
          if (rlast) begin
            r_state_nx = R_IDLE;
          end else begin
            rd_en   = 1'b1;
            rd_addr = rb.addr + BEAT;
          end
        end
      end
      default: r_state_nx = R_IDLE;
    endcase
    rdata = (rvalid && !r_err) ? mem_q : '0;
    rresp = (rvalid && r_err) ? AXI4_RESP_SLVERR : AXI4_RESP_OKAY;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= R_IDLE;
      rb      <= '0;
      r_err   <= 1'b0;
      r_wait  <= '0;
    end else begin
      r_state <= r_state_nx;
      if (arready && arvalid) begin
        rb.addr <= {1'b0, araddr};
        rb.id   <= arid;
        rb.len  <= arlen;
        rb.cnt  <= '0;
        r_wait  <= '0;
      end else if (r_state == R_WAIT) begin
        r_wait  <= r_wait + 16'd1;
      end
      if (rd_en) r_err <= !in_range(rd_addr);
      if (rvalid && rready && !rlast) begin
        rb.addr <= rb.addr + BEAT;
        rb.cnt  <= rb.cnt + 8'd1;
      end
    end
  end

  assign rid = rb.id;

  axi4_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_mem (
    .clock (clock),
    .we    (mem_we),
    .w_idx (word_idx(wb.addr)),
    .wdata (wdata),
    .wstrb (wstrb),
    .re    (rd_en),
    .r_idx (word_idx(rd_addr)),
    .rdata (mem_q)
  );

endmodule

// File: tb/tb_axi4_mem_slave.sv
// tb_axi4_mem_slave
//   Directed stimulus with a scoreboard: expected B and R responses are
//   queued when traffic is issued, and a negedge monitor compares them
//   whenever the DUT presents bvalid/rvalid.
module tb_axi4_mem_slave;

  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] SLV = 2'b10;

  logic        clock = 1'b0;
  logic        reset;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic        wvalid, wready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic        rvalid, rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic        rlast;

  always #5 clock = ~clock;

  axi4_mem_slave dut (
    .clock(clock), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rid(rid), .rlast(rlast)
  );

  typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;
  typedef struct { logic [63:0] data; logic [1:0] resp; logic last; logic [3:0] id; } rexp_t;

  bexp_t exp_b[$];
  rexp_t exp_r[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // hand-computed data patterns
  localparam logic [63:0] D0 = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] D1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D2 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] D3 = 64'h9999_0000_AAAA_1111;
  localparam logic [63:0] M0 = 64'h1234_5678_CCCC_DDDD; // D0 after strb F0 write
  localparam logic [63:0] E0 = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [63:0] Q0 = 64'h0F0F_0F0F_0F0F_0F0F;
  localparam logic [63:0] Q1 = 64'hF0F0_F0F0_F0F0_F0F0;
  localparam logic [63:0] P0 = 64'h0000_0000_0000_0100;
  localparam logic [63:0] P1 = 64'h0000_0000_0000_0101;
  localparam logic [63:0] P2 = 64'h0000_0000_0000_0102;
  localparam logic [63:0] P3 = 64'h0000_0000_0000_0103;
  localparam logic [63:0] N0 = 64'hBAAD_0000_0000_0000;
  localparam logic [63:0] N1 = 64'hBAAD_0000_0000_0001;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_b(input logic [3:0] id, input logic [1:0] resp);
    bexp_t e;
    e.id = id; e.resp = resp;
    exp_b.push_back(e);
  endtask

  task automatic push_r(input logic [63:0] d, input logic [1:0] resp, input logic last, input logic [3:0] id);
    rexp_t e;
    e.data = d; e.resp = resp; e.last = last; e.id = id;
    exp_r.push_back(e);
  endtask

  // monitor: compare the queue head every cycle a response is shown (so a
  // stalled beat must stay stable), pop when the handshake will complete
  always @(negedge clock) begin
    if (!reset) begin
      if (bvalid) begin
        if (exp_b.size() == 0) chk("b_unexpected", 64'(bvalid), 64'd0);
        else begin
          chk("bid", 64'(bid), 64'(exp_b[0].id));
          chk("bresp", 64'(bresp), 64'(exp_b[0].resp));
          if (bready) void'(exp_b.pop_front());
        end
      end
      if (rvalid) begin
        if (exp_r.size() == 0) chk("r_unexpected", 64'(rvalid), 64'd0);
        else begin
          chk("rdata", rdata, exp_r[0].data);
          chk("rresp", 64'(rresp), 64'(exp_r[0].resp));
          chk("rlast", 64'(rlast), 64'(exp_r[0].last));
          chk("rid", 64'(rid), 64'(exp_r[0].id));
          if (rready) void'(exp_r.pop_front());
        end
      end
    end
  end

  // all drivers run at posedge+1 and return at posedge+1
  task automatic send_aw(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    awvalid = 1'b1; awaddr = a; awid = id; awlen = len;
    @(negedge clock);
    for (int n = 0; n < 50 && !awready; n++) @(negedge clock);
    if (!awready) chk("aw_timeout", 64'(awready), 64'd1);
    @(posedge clock); #1 awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] s, input logic last);
    wvalid = 1'b1; wdata = d; wstrb = s; wlast = last;
    @(negedge clock);
    for (int n = 0; n < 50 && !wready; n++) @(negedge clock);
    if (!wready) chk("w_timeout", 64'(wready), 64'd1);
    @(posedge clock); #1 wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    arvalid = 1'b1; araddr = a; arid = id; arlen = len;
    @(negedge clock);
    for (int n = 0; n < 50 && !arready; n++) @(negedge clock);
    if (!arready) chk("ar_timeout", 64'(arready), 64'd1);
    @(posedge clock); #1 arvalid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && (exp_b.size() != 0 || exp_r.size() != 0); n++) @(posedge clock);
    #1;
    if (exp_b.size() != 0 || exp_r.size() != 0)
      chk("drain_timeout", 64'(exp_b.size() + exp_r.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    awvalid = 0; awaddr = 0; awid = 0; awlen = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0;
    arvalid = 0; araddr = 0; arid = 0; arlen = 0;
    bready = 1'b1; rready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_awready", 64'(awready), 64'd1);
    chk("rst_arready", 64'(arready), 64'd1);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rlast", 64'(rlast), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_ids_resps", {52'd0, bid, rid, bresp, rresp}, 64'd0);
    @(posedge clock); #1 reset = 1'b0;

    // prime words 0..3
    push_b(4'd3, OK);
    send_aw(32'h8000_0000, 4'd3, 8'd3);
    send_w(D0, 8'hFF, 1'b0); send_w(D1, 8'hFF, 1'b0);
    send_w(D2, 8'hFF, 1'b0); send_w(D3, 8'hFF, 1'b1);
    drain();

    // upper-half strobe merge
    push_b(4'd5, OK);
    send_aw(32'h8000_0004, 4'd5, 8'd0);
    send_w(64'h1234_5678_0000_0000, 8'hF0, 1'b1);
    drain();
    push_r(M0, OK, 1'b1, 4'd6);
    send_ar(32'h8000_0004, 4'd6, 8'd0);
    drain();

    // 4-beat read with rready toggling 1,0,1,0
    push_r(M0, OK, 1'b0, 4'd4); push_r(D1, OK, 1'b0, 4'd4);
    push_r(D2, OK, 1'b0, 4'd4); push_r(D3, OK, 1'b1, 4'd4);
    send_ar(32'h8000_0000, 4'd4, 8'd3);
    for (int c = 0; c < 40 && exp_r.size() != 0; c++) begin
      @(posedge clock); #1 rready = ~rready;
    end
    rready = 1'b1;
    drain();

    // below-range read
    push_r(64'd0, SLV, 1'b1, 4'd2);
    send_ar(32'h7FFF_FFF8, 4'd2, 8'd0);
    drain();

    // burst crossing the top of the array: first beat lands, second errors
    push_b(4'd1, SLV);
    send_aw(32'h8000_7FF8, 4'd1, 8'd1);
    send_w(E0, 8'hFF, 1'b0); send_w(64'h5A5A_5A5A_5A5A_5A5A, 8'hFF, 1'b1);
    drain();

    // fully out-of-range write must not alias onto word 0
    push_b(4'd2, SLV);
    send_aw(32'h8000_8000, 4'd2, 8'd0);
    send_w(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
    drain();
    push_r(E0, OK, 1'b0, 4'd3); push_r(64'd0, SLV, 1'b1, 4'd3);
    send_ar(32'h8000_7FF8, 4'd3, 8'd1);
    drain();
    push_r(M0, OK, 1'b1, 4'd4);
    send_ar(32'h8000_0000, 4'd4, 8'd0);
    drain();

    // wlast asserted early
    push_b(4'd6, SLV);
    send_aw(32'h8000_0400, 4'd6, 8'd1);
    send_w(64'h1, 8'hFF, 1'b1); send_w(64'h2, 8'hFF, 1'b1);
    drain();

    // write and read of one word on the same edge: read sees old data
    push_b(4'd7, OK);
    send_aw(32'h8000_0200, 4'd7, 8'd0);
    send_w(Q0, 8'hFF, 1'b1);
    drain();
    push_b(4'd8, OK); push_r(Q0, OK, 1'b1, 4'd9);
    send_aw(32'h8000_0200, 4'd8, 8'd0);
    wvalid = 1'b1; wdata = Q1; wstrb = 8'hFF; wlast = 1'b1;
    arvalid = 1'b1; araddr = 32'h8000_0200; arid = 4'd9; arlen = 8'd0;
    @(negedge clock);
    chk("same_edge_wready", 64'(wready), 64'd1);
    chk("same_edge_arready", 64'(arready), 64'd1);
    @(posedge clock); #1 wvalid = 1'b0; arvalid = 1'b0;
    drain();
    push_r(Q1, OK, 1'b1, 4'd10);
    send_ar(32'h8000_0200, 4'd10, 8'd0);
    drain();

    // AW and AR together, bready held low for 5 cycles
    bready = 1'b0;
    push_b(4'd11, OK); push_r(M0, OK, 1'b1, 4'd12);
    awvalid = 1'b1; awaddr = 32'h8000_0300; awid = 4'd11; awlen = 8'd0;
    arvalid = 1'b1; araddr = 32'h8000_0000; arid = 4'd12; arlen = 8'd0;
    @(negedge clock);
    chk("dual_awready", 64'(awready), 64'd1);
    chk("dual_arready", 64'(arready), 64'd1);
    @(posedge clock); #1 awvalid = 1'b0; arvalid = 1'b0;
    send_w(64'h7777_7777_7777_7777, 8'hFF, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      chk("bvalid_held", 64'(bvalid), 64'd1);
    end
    chk("read_done_under_b_stall", 64'(exp_r.size()), 64'd0);
    @(posedge clock); #1 bready = 1'b1;
    drain();

    // reset on beat 2 of a 4-beat burst; beats 3 and 4 never land
    push_b(4'd13, OK);
    send_aw(32'h8000_0100, 4'd13, 8'd3);
    send_w(P0, 8'hFF, 1'b0); send_w(P1, 8'hFF, 1'b0);
    send_w(P2, 8'hFF, 1'b0); send_w(P3, 8'hFF, 1'b1);
    drain();
    send_aw(32'h8000_0100, 4'd14, 8'd3);
    send_w(N0, 8'hFF, 1'b0);
    wvalid = 1'b1; wdata = N1; wstrb = 8'hFF; wlast = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0; wvalid = 1'b0;
    @(negedge clock);
    chk("post_rst_awready", 64'(awready), 64'd1);
    chk("post_rst_wready", 64'(wready), 64'd0);
    chk("post_rst_bvalid", 64'(bvalid), 64'd0);
    @(posedge clock); #1;
    push_r(P2, OK, 1'b0, 4'd15); push_r(P3, OK, 1'b1, 4'd15);
    send_ar(32'h8000_0110, 4'd15, 8'd1);
    drain();
    push_r(N0, OK, 1'b1, 4'd1);
    send_ar(32'h8000_0100, 4'd1, 8'd0);
    drain();

    repeat (3) @(posedge clock);
    chk("b_queue_left", 64'(exp_b.size()), 64'd0);
    chk("r_queue_left", 64'(exp_r.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
